// File: rtl/sevenseg_scan_reader.sv
// Recovers hex nibbles from a multiplexed seven-segment bus and hands off full frames over valid/ready.
// Optional macro SEVENSEG_HEX_EN: also accept the A..F glyphs as legal digits.
module sevenseg_scan_reader #(
    parameter int NDIGITS       = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [6:0]             segments,
    input  logic [NDIGITS-1:0]     digit_sel,
    input  logic                   clear,
    output logic [4*NDIGITS-1:0]   frame_value,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic [NDIGITS-1:0]     digit_valid,
    output logic                   pattern_err,
    output logic                   overrun
);

    localparam int SW = NDIGITS + 7;
    localparam logic [7:0] CNT_SAT = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 2);
    localparam logic [NDIGITS-1:0] SEL_ONE = NDIGITS'(1);

    // Returns {legal, nibble} for a segment pattern (abcdefg, active-high).
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'b1111110: decode_seg = {1'b1, 4'h0};
            7'b0110000: decode_seg = {1'b1, 4'h1};
            7'b1101101: decode_seg = {1'b1, 4'h2};
            7'b1111001: decode_seg = {1'b1, 4'h3};
            7'b0110011: decode_seg = {1'b1, 4'h4};
            7'b1011011: decode_seg = {1'b1, 4'h5};
            7'b1011111: decode_seg = {1'b1, 4'h6};
            7'b1110000: decode_seg = {1'b1, 4'h7};
            7'b1111111: decode_seg = {1'b1, 4'h8};
            7'b1110011: decode_seg = {1'b1, 4'h9};
`ifdef SEVENSEG_HEX_EN
            7'b1110111: decode_seg = {1'b1, 4'hA};
            7'b0011111: decode_seg = {1'b1, 4'hB};
            7'b1001110: decode_seg = {1'b1, 4'hC};
            7'b0111101: decode_seg = {1'b1, 4'hD};
            7'b1001111: decode_seg = {1'b1, 4'hE};
            7'b1000111: decode_seg = {1'b1, 4'hF};
`endif
            default:    decode_seg = 5'b0_0000;
        endcase
    endfunction

    logic [6:0]           seg_meta_r, seg_sync_r;
    logic [NDIGITS-1:0]   sel_meta_r, sel_sync_r;
    logic [SW-1:0]        prev_r;
    logic [7:0]           cnt_r;
    logic [NDIGITS-1:0]   mask_r;
    logic [4*NDIGITS-1:0] work_r, frame_value_r;
    logic                 frame_valid_r, pattern_err_r, overrun_r;

    logic [SW-1:0]        sample_s;
    logic                 same_s, onehot_s, cap_s, err_set_s, complete_s;
    logic [4:0]           dec_s;
    logic [7:0]           cnt_nx_s;
    logic [NDIGITS-1:0]   mask_nx_s;
    logic [4*NDIGITS-1:0] work_nx_s;

    // Stability filter, decode and next-state of the capture mask and working value.
    always_comb begin
        sample_s  = {sel_sync_r, seg_sync_r};
        same_s    = (sample_s == prev_r);
        onehot_s  = (sel_sync_r != '0) && ((sel_sync_r & (sel_sync_r - SEL_ONE)) == '0);
        dec_s     = decode_seg(seg_sync_r);
        // Fires on the transition into CNT_SAT only, so one capture per dwell.
        cap_s     = same_s && (cnt_r == CNT_CAP) && onehot_s;
        cnt_nx_s  = same_s ? ((cnt_r == CNT_SAT) ? cnt_r : cnt_r + 8'd1) : 8'd0;
        err_set_s = cap_s && !dec_s[4];
        mask_nx_s = mask_r;
        work_nx_s = work_r;
        for (int i = 0; i < NDIGITS; i++) begin
            mask_nx_s[i]       = (cap_s && sel_sync_r[i]) ? dec_s[4] : mask_r[i];
            work_nx_s[4*i +: 4] = (cap_s && sel_sync_r[i] && dec_s[4]) ? dec_s[3:0]
                                                                      : work_r[4*i +: 4];
        end
        complete_s = &mask_nx_s;
    end

    // Synchronizers, filter state, frame assembly and handoff.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_meta_r    <= 7'd0;
            seg_sync_r    <= 7'd0;
            sel_meta_r    <= '0;
            sel_sync_r    <= '0;
            prev_r        <= '0;
            cnt_r         <= 8'd0;
            mask_r        <= '0;
            work_r        <= '0;
            frame_value_r <= '0;
            frame_valid_r <= 1'b0;
            pattern_err_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            seg_meta_r <= segments;
            seg_sync_r <= seg_meta_r;
            sel_meta_r <= digit_sel;
            sel_sync_r <= sel_meta_r;
            prev_r     <= sample_s;
            cnt_r      <= cnt_nx_s;
            if (clear) begin
                mask_r        <= '0;
                pattern_err_r <= 1'b0;
                overrun_r     <= 1'b0;
                frame_valid_r <= frame_valid_r && !frame_ready;
            end else begin
                work_r <= work_nx_s;
                if (err_set_s) begin
                    pattern_err_r <= 1'b1;
                end
                if (complete_s) begin
                    mask_r <= '0;
                    // A handoff in the same cycle frees the slot, so no overrun.
                    if (frame_valid_r && !frame_ready) begin
                        overrun_r <= 1'b1;
                    end else begin
                        frame_value_r <= work_nx_s;
                        frame_valid_r <= 1'b1;
                    end
                end else begin
                    mask_r        <= mask_nx_s;
                    frame_valid_r <= frame_valid_r && !frame_ready;
                end
            end
        end
    end

    assign frame_value = frame_value_r;
    assign frame_valid = frame_valid_r;
    assign digit_valid = mask_r;
    assign pattern_err = pattern_err_r;
    assign overrun     = overrun_r;

endmodule
